// File: rtl/change_dispenser_if.sv
// change_dispenser_if: payout request, coin-eject handshake and tube status bundle.
// The master side requests payouts and acknowledges ejects; the slave side is the dispenser.
interface change_dispenser_if #(
    parameter int unsigned TUBE_DEPTH = 15
);
    localparam int unsigned CNT_W = $clog2(TUBE_DEPTH + 1);

    logic [7:0]       change_in;
    logic             change_valid;
    logic             eject_ready;
    logic             refill;
    logic [7:0]       coin_value;
    logic             coin_valid;
    logic             busy;
    logic             done;
    logic [7:0]       shortfall;
    logic             overrun;
    logic [CNT_W-1:0] cnt50;
    logic [CNT_W-1:0] cnt20;
    logic [CNT_W-1:0] cnt10;
    logic [15:0]      dispensed_total;

    modport master (
        output change_in, change_valid, eject_ready, refill,
        input  coin_value, coin_valid, busy, done, shortfall, overrun,
        input  cnt50, cnt20, cnt10, dispensed_total
    );

    modport slave (
        input  change_in, change_valid, eject_ready, refill,
        output coin_value, coin_valid, busy, done, shortfall, overrun,
        output cnt50, cnt20, cnt10, dispensed_total
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 50/20/10 coin payout from finite tubes with eject handshake.
// Optional audit counter of dispensed value is enabled with `define CHANGE_AUDIT_EN.
module change_dispenser #(
    parameter int unsigned TUBE_DEPTH = 15,
    parameter int unsigned EJECT_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    change_dispenser_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(TUBE_DEPTH + 1);
    localparam int unsigned GAP_W    = (EJECT_GAP > 1) ? $clog2(EJECT_GAP) : 1;
    localparam int unsigned GAP_LOAD = (EJECT_GAP > 0) ? EJECT_GAP - 1 : 0;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(TUBE_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_EJECT  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       r_state,      w_state_nxt;
    logic [7:0]       r_remaining,  w_remaining_nxt;
    logic [7:0]       r_coin_value, w_coin_value_nxt;
    logic             r_coin_valid, w_coin_valid_nxt;
    logic [7:0]       r_shortfall,  w_shortfall_nxt;
    logic [GAP_W-1:0] r_gap_cnt,    w_gap_cnt_nxt;
    logic [CNT_W-1:0] r_cnt50,      w_cnt50_nxt;
    logic [CNT_W-1:0] r_cnt20,      w_cnt20_nxt;
    logic [CNT_W-1:0] r_cnt10,      w_cnt10_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;
    logic [7:0]       w_pick;
    logic             w_xfer;

    assign w_xfer = r_coin_valid & bus.eject_ready;

    // Largest denomination that fits the remaining amount and still has coins.
    always_comb begin
        w_pick = 8'd0;
        if (r_remaining >= 8'd50 && r_cnt50 != '0) begin
            w_pick = 8'd50;
        end else if (r_remaining >= 8'd20 && r_cnt20 != '0) begin
            w_pick = 8'd20;
        end else if (r_remaining >= 8'd10 && r_cnt10 != '0) begin
            w_pick = 8'd10;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_remaining_nxt  = r_remaining;
        w_coin_value_nxt = r_coin_value;
        w_coin_valid_nxt = r_coin_valid;
        w_shortfall_nxt  = r_shortfall;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_cnt50_nxt      = r_cnt50;
        w_cnt20_nxt      = r_cnt20;
        w_cnt10_nxt      = r_cnt10;

        case (r_state)
            S_IDLE: begin
                if (bus.change_valid && bus.change_in != 8'd0) begin
                    w_remaining_nxt = bus.change_in;
                    w_shortfall_nxt = 8'd0;
                    w_state_nxt     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_remaining == 8'd0) begin
                    w_state_nxt = S_DONE;
                end else if (w_pick != 8'd0) begin
                    w_coin_value_nxt = w_pick;
                    w_coin_valid_nxt = 1'b1;
                    w_state_nxt      = S_EJECT;
                end else begin
                    w_shortfall_nxt = r_remaining;
                    w_remaining_nxt = 8'd0;
                    w_state_nxt     = S_DONE;
                end
            end
            S_EJECT: begin
                if (w_xfer) begin
                    w_remaining_nxt  = r_remaining - r_coin_value;
                    w_coin_valid_nxt = 1'b0;
                    w_coin_value_nxt = 8'd0;
                    case (r_coin_value)
                        8'd50: if (r_cnt50 != '0) w_cnt50_nxt = r_cnt50 - CNT_W'(1);
                        8'd20: if (r_cnt20 != '0) w_cnt20_nxt = r_cnt20 - CNT_W'(1);
                        8'd10: if (r_cnt10 != '0) w_cnt10_nxt = r_cnt10 - CNT_W'(1);
                        default: ;
                    endcase
                    if (EJECT_GAP == 0) begin
                        w_state_nxt = S_SELECT;
                    end else begin
                        w_gap_cnt_nxt = GAP_W'(GAP_LOAD);
                        w_state_nxt   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_SELECT;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Refill overrides any decrement made in the same cycle.
        if (bus.refill) begin
            w_cnt50_nxt = FULL;
            w_cnt20_nxt = FULL;
            w_cnt10_nxt = FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_remaining  <= 8'd0;
            r_coin_value <= 8'd0;
            r_coin_valid <= 1'b0;
            r_shortfall  <= 8'd0;
            r_gap_cnt    <= '0;
            r_cnt50      <= FULL;
            r_cnt20      <= FULL;
            r_cnt10      <= FULL;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_coin_value <= w_coin_value_nxt;
            r_coin_valid <= w_coin_valid_nxt;
            r_shortfall  <= w_shortfall_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_cnt50      <= w_cnt50_nxt;
            r_cnt20      <= w_cnt20_nxt;
            r_cnt10      <= w_cnt10_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
            r_overrun    <= bus.change_valid && (r_state != S_IDLE);
        end
    end

    assign bus.coin_value = r_coin_value;
    assign bus.coin_valid = r_coin_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.shortfall  = r_shortfall;
    assign bus.overrun    = r_overrun;
    assign bus.cnt50      = r_cnt50;
    assign bus.cnt20      = r_cnt20;
    assign bus.cnt10      = r_cnt10;

`ifdef CHANGE_AUDIT_EN
    logic [15:0] r_total;
    logic [16:0] w_total_sum;

    assign w_total_sum = {1'b0, r_total} + 17'(r_coin_value);

    // Saturating audit of value handed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= 16'd0;
        end else if (w_xfer) begin
            r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
        end
    end

    assign bus.dispensed_total = r_total;
`else
    assign bus.dispensed_total = 16'd0;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed vector table, hand-written corner sequences and
// randomized payouts checked against a greedy arithmetic model of the dispenser.
module tb_change_dispenser;
    localparam int TUBE_DEPTH = 15;
    localparam int EJECT_GAP  = 2;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    change_dispenser_if #(.TUBE_DEPTH(TUBE_DEPTH)) bif ();

    change_dispenser #(
        .TUBE_DEPTH(TUBE_DEPTH),
        .EJECT_GAP (EJECT_GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    typedef struct {
        int             pre;      // 0 none, 1 refill, 2 reset before the payout
        int             amt;
        int             n_coins;
        logic [5:0][7:0] coins;   // coins[0] is the first coin ejected
        int             sf;
        int             c50;
        int             c20;
        int             c10;
        int             total;    // audit total when the audit counter is built in
    } vec_t;

    vec_t tbl [8];

    int vectors;
    int miscompares;

    logic [7:0] obs_coins [$];
    int         exp_coins [$];
    int         got_done;
    int         stab_err;
    int         gap_err;

    int m50, m20, m10, mtotal, exp_sf;

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int exp_total(input int t);
`ifdef CHANGE_AUDIT_EN
        return t;
`else
        return 0 * t;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_refill();
        bif.refill = 1'b1;
        tick();
        bif.refill = 1'b0;
    endtask

    task automatic start_payout(input int amt);
        bif.change_in    = 8'(amt);
        bif.change_valid = 1'b1;
        tick();
        bif.change_valid = 1'b0;
        bif.change_in    = 8'd0;
    endtask

    task automatic wait_coin(input string name);
        int ok;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (bif.coin_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(name, ok, 1);
    endtask

    // Runs a payout to completion, recording transfers and handshake/gap violations.
    task automatic finish_payout(input int unsigned rdy_pct);
        logic       prev_valid, prev_xfer, xfer;
        logic [7:0] prev_val;
        int         low_run, seen_xfer;
        obs_coins.delete();
        got_done   = 0;
        stab_err   = 0;
        gap_err    = 0;
        low_run    = 0;
        seen_xfer  = 0;
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
        prev_val   = 8'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_valid && !prev_xfer && (!bif.coin_valid || bif.coin_value != prev_val))
                stab_err++;
            if (bif.coin_valid) begin
                if (!prev_valid && seen_xfer != 0 && low_run != EJECT_GAP + 1)
                    gap_err++;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (bif.done) begin
                got_done = 1;
                break;
            end
            bif.eject_ready = ($urandom_range(99) < rdy_pct);
            xfer = bif.coin_valid && bif.eject_ready;
            if (xfer) begin
                obs_coins.push_back(bif.coin_value);
                seen_xfer = 1;
            end
            prev_valid = bif.coin_valid;
            prev_val   = bif.coin_value;
            prev_xfer  = xfer;
            tick();
        end
        bif.eject_ready = 1'b0;
    endtask

    task automatic check_done_pulse();
        chk("done_seen", got_done, 1);
        chk("stable_while_waiting", stab_err, 0);
        chk("eject_gap", gap_err, 0);
        tick();
        chk("done_one_cycle", int'(bif.done), 0);
        chk("idle_after_done", int'(bif.busy), 0);
    endtask

    // Greedy payout from the specification's rules, applied to model tube counts.
    task automatic model_pay(input int amt);
        int rem;
        rem = amt;
        exp_sf = 0;
        exp_coins.delete();
        while (rem > 0) begin
            if (rem >= 50 && m50 > 0) begin
                exp_coins.push_back(50); rem -= 50; m50--;
            end else if (rem >= 20 && m20 > 0) begin
                exp_coins.push_back(20); rem -= 20; m20--;
            end else if (rem >= 10 && m10 > 0) begin
                exp_coins.push_back(10); rem -= 10; m10--;
            end else begin
                exp_sf = rem;
                rem = 0;
            end
        end
        mtotal += amt - exp_sf;
        if (mtotal > 65535) mtotal = 65535;
    endtask

    initial begin
        int amt, n;
        vectors     = 0;
        miscompares = 0;
        rst_n            = 1'b0;
        bif.change_in    = 8'd0;
        bif.change_valid = 1'b0;
        bif.eject_ready  = 1'b0;
        bif.refill       = 1'b0;

        tbl[0] = '{2,  20, 1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20},   0, 15, 14, 15,  20};
        tbl[1] = '{1, 255, 5, {8'd0, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50}, 5, 10, 15, 15, 270};
        tbl[2] = '{0, 250, 5, {8'd0, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50}, 0,  5, 15, 15, 520};
        tbl[3] = '{0, 250, 5, {8'd0, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50}, 0,  0, 15, 15, 770};
        tbl[4] = '{0,  80, 4, {8'd0, 8'd0, 8'd20, 8'd20, 8'd20, 8'd20},  0,  0, 11, 15, 850};
        tbl[5] = '{1,  25, 1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20},    5, 15, 14, 15, 870};
        tbl[6] = '{2,  70, 2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd20, 8'd50},   0, 14, 14, 15,  70};
        tbl[7] = '{0,  20, 1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20},    0, 14, 13, 15,  90};

        tick();
        tick();
        chk("rst_busy",  int'(bif.busy), 0);
        chk("rst_valid", int'(bif.coin_valid), 0);
        chk("rst_value", int'(bif.coin_value), 0);
        chk("rst_cnt50", int'(bif.cnt50), TUBE_DEPTH);
        chk("rst_total", int'(bif.dispensed_total), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pre == 1) do_refill();
            else if (tbl[i].pre == 2) do_reset();
            start_payout(tbl[i].amt);
            finish_payout((i % 2 == 0) ? 100 : 60);
            chk("tbl_n_coins", obs_coins.size(), tbl[i].n_coins);
            n = (obs_coins.size() < tbl[i].n_coins) ? obs_coins.size() : tbl[i].n_coins;
            for (int k = 0; k < n; k++)
                chk("tbl_coin", int'(obs_coins[k]), int'(tbl[i].coins[k]));
            chk("tbl_shortfall", int'(bif.shortfall), tbl[i].sf);
            chk("tbl_cnt50", int'(bif.cnt50), tbl[i].c50);
            chk("tbl_cnt20", int'(bif.cnt20), tbl[i].c20);
            chk("tbl_cnt10", int'(bif.cnt10), tbl[i].c10);
            chk("tbl_total", int'(bif.dispensed_total), exp_total(tbl[i].total));
            check_done_pulse();
        end

        // Zero amount is ignored.
        start_payout(0);
        chk("zero_ignored", int'(bif.busy), 0);

        // Eject stalled five cycles with a stray request in the window.
        do_refill();
        start_payout(50);
        wait_coin("ovr_coin_up");
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", int'(bif.coin_valid), 1);
            chk("hold_value", int'(bif.coin_value), 50);
            if (k == 2) chk("overrun_pulse", int'(bif.overrun), 1);
            if (k == 3) chk("overrun_clear", int'(bif.overrun), 0);
            bif.change_valid = (k == 1);
            bif.change_in    = (k == 1) ? 8'd30 : 8'd0;
            tick();
        end
        finish_payout(100);
        chk("ovr_n_coins", obs_coins.size(), 1);
        chk("ovr_shortfall", int'(bif.shortfall), 0);
        chk("ovr_cnt50", int'(bif.cnt50), 14);
        check_done_pulse();

        // Refill in the same cycle as a transfer leaves the tube full.
        start_payout(20);
        wait_coin("rf_coin_up");
        chk("rf_coin_value", int'(bif.coin_value), 20);
        bif.eject_ready = 1'b1;
        bif.refill      = 1'b1;
        tick();
        bif.eject_ready = 1'b0;
        bif.refill      = 1'b0;
        chk("rf_xfer_taken", int'(bif.coin_valid), 0);
        chk("rf_cnt20", int'(bif.cnt20), TUBE_DEPTH);
        finish_payout(100);
        chk("rf_shortfall", int'(bif.shortfall), 0);
        check_done_pulse();

        // Asynchronous reset in the middle of an eject.
        start_payout(50);
        wait_coin("rst_coin_up");
        bif.eject_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(bif.coin_valid), 0);
        chk("arst_value", int'(bif.coin_value), 0);
        chk("arst_busy", int'(bif.busy), 0);
        chk("arst_done", int'(bif.done), 0);
        chk("arst_overrun", int'(bif.overrun), 0);
        chk("arst_shortfall", int'(bif.shortfall), 0);
        chk("arst_total", int'(bif.dispensed_total), 0);
        chk("arst_cnt50", int'(bif.cnt50), TUBE_DEPTH);
        chk("arst_cnt20", int'(bif.cnt20), TUBE_DEPTH);
        chk("arst_cnt10", int'(bif.cnt10), TUBE_DEPTH);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized payouts against the greedy model.
        m50 = TUBE_DEPTH; m20 = TUBE_DEPTH; m10 = TUBE_DEPTH; mtotal = 0;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(3) == 0) begin
                do_refill();
                m50 = TUBE_DEPTH; m20 = TUBE_DEPTH; m10 = TUBE_DEPTH;
            end
            amt = int'($urandom_range(255, 1));
            start_payout(amt);
            model_pay(amt);
            finish_payout($urandom_range(100, 30));
            chk("rnd_n_coins", obs_coins.size(), exp_coins.size());
            n = (obs_coins.size() < exp_coins.size()) ? obs_coins.size() : exp_coins.size();
            for (int k = 0; k < n; k++)
                chk("rnd_coin", int'(obs_coins[k]), exp_coins[k]);
            chk("rnd_shortfall", int'(bif.shortfall), exp_sf);
            chk("rnd_cnt50", int'(bif.cnt50), m50);
            chk("rnd_cnt20", int'(bif.cnt20), m20);
            chk("rnd_cnt10", int'(bif.cnt10), m10);
            chk("rnd_total", int'(bif.dispensed_total), exp_total(mtotal));
            check_done_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
